// File: rtl/key_scan_7seg.sv
// Debounced 16-key scanner that shifts accepted key codes into a hex digit
// register and drives a multiplexed 7-segment display. Optional blanking of
// never-written digits is enabled by defining KEY_SCAN_7SEG_BLANK_EN.
module key_scan_7seg #(
    parameter int N_DIGITS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REFRESH_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             d,
    output logic [6:0]              y,
    output logic [N_DIGITS-1:0]     sel,
    output logic                    key_valid,
    output logic [3:0]              key_code,
    output logic [4*N_DIGITS-1:0]   value
);

    localparam int VAL_W = 4 * N_DIGITS;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0]  RF_MAX  = RF_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

`ifdef KEY_SCAN_7SEG_BLANK_EN
    localparam logic [6:0] RESET_Y = 7'h00;
`else
    localparam logic [6:0] RESET_Y = 7'h7E;
`endif

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] seg;
        case (h)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [15:0]          d_q, d_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic [15:0]          stable_q, stable_d;
    logic                 lockout_q, lockout_d;
    logic                 key_valid_q, key_valid_d;
    logic [3:0]           key_code_q, key_code_d;
    logic [VAL_W-1:0]     value_q, value_d;
    logic [RF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]     dig_idx_q, dig_idx_d;
    logic [N_DIGITS-1:0]  sel_q, sel_d;
    logic [6:0]           y_q, y_d;
    logic                 press;
    logic [3:0]           cur_digit;
    logic                 cur_written;
`ifdef KEY_SCAN_7SEG_BLANK_EN
    logic [N_DIGITS-1:0]  written_q, written_d;
`endif

    // The counter restarts on every change of the sampled vector; stable
    // follows d_q only once it has held for the full debounce window.
    always_comb begin
        d_d      = d;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        if (d != d_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            stable_d = d_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // A press is only recognised out of the all-released state; lockout
    // suppresses rollover until every key is released again.
    always_comb begin
        press       = (stable_q != 16'h0000) && !lockout_q;
        key_valid_d = press;
        key_code_d  = key_code_q;
        value_d     = value_q;
        lockout_d   = lockout_q;
`ifdef KEY_SCAN_7SEG_BLANK_EN
        written_d   = written_q;
`endif
        if (press) begin
            key_code_d = lowest_set(stable_q);
            value_d    = (value_q << 4) | VAL_W'(lowest_set(stable_q));
            lockout_d  = 1'b1;
`ifdef KEY_SCAN_7SEG_BLANK_EN
            written_d  = (written_q << 1) | N_DIGITS'(1);
`endif
        end else if (stable_q == 16'h0000) begin
            lockout_d  = 1'b0;
        end
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q;
        dig_idx_d = dig_idx_q;
        if (ref_cnt_q == RF_MAX) begin
            ref_cnt_d = '0;
            dig_idx_d = (dig_idx_q == IDX_MAX) ? '0 : dig_idx_q + 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + 1'b1;
        end
    end

    // sel and y are both derived from the same index so they stay aligned.
    always_comb begin
        sel_d       = '0;
        cur_digit   = 4'h0;
        cur_written = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig_idx_q == IDX_W'(i)) begin
                sel_d[i]  = 1'b1;
                cur_digit = value_q[4*i +: 4];
`ifdef KEY_SCAN_7SEG_BLANK_EN
                cur_written = written_q[i];
`endif
            end
        end
        y_d = cur_written ? font(cur_digit) : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q         <= '0;
            db_cnt_q    <= '0;
            stable_q    <= '0;
            lockout_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            value_q     <= '0;
            ref_cnt_q   <= '0;
            dig_idx_q   <= '0;
            sel_q       <= N_DIGITS'(1);
            y_q         <= RESET_Y;
`ifdef KEY_SCAN_7SEG_BLANK_EN
            written_q   <= '0;
`endif
        end else begin
            d_q         <= d_d;
            db_cnt_q    <= db_cnt_d;
            stable_q    <= stable_d;
            lockout_q   <= lockout_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            value_q     <= value_d;
            ref_cnt_q   <= ref_cnt_d;
            dig_idx_q   <= dig_idx_d;
            sel_q       <= sel_d;
            y_q         <= y_d;
`ifdef KEY_SCAN_7SEG_BLANK_EN
            written_q   <= written_d;
`endif
        end
    end

    assign y         = y_q;
    assign sel       = sel_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign value     = value_q;

endmodule
